// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter and the CPU top.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_ADDR_W = 32;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, host and data-memory signals of the arbiter grouped as one bus.
// slave = arbiter side, master = CPU/host/memory side.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_lock;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_we;
  logic              mem_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_lock, host_we, host_addr, host_wdata,
    input  mem_dout,
    output cpu_rdata, cpu_stall,
    output host_gnt, host_rvalid, host_rdata,
    output mem_we, mem_oe, mem_addr, mem_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_lock, host_we, host_addr, host_wdata,
    output mem_dout,
    input  cpu_rdata, cpu_stall,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_we, mem_oe, mem_addr, mem_din
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating host starvation counter; o_hit flags that the host has waited MAX_WAIT cycles.
module arb_wait_counter #(
  parameter int unsigned WAIT_W   = 3,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  logic [WAIT_W-1:0] r_cnt;

  assign o_hit = (r_cnt == WAIT_W'(MAX_WAIT));

  // Clear wins over increment; holds at MAX_WAIT instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_hit) begin
      r_cnt <= r_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store path and the host port.
// Define DMEM_ARB_STATS_EN to add the stall_cnt / host_cnt statistics outputs.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic        clk,
  input  logic        rstn,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] host_cnt
`endif
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_host_rdata;

  logic              w_host_own;
  logic              w_cpu_own;
  logic              w_gnt;
  logic              w_stall;
  logic              w_inc;
  logic              w_clr;
  logic              w_hit;
  logic              w_own_req;
  logic              w_own_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;

  arb_wait_counter #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_hit (w_hit)
  );

  // Ownership decode; everything is gated while rstn is low so no access leaks out of reset.
  always_comb begin
    w_host_own  = 1'b0;
    w_cpu_own   = 1'b0;
    w_gnt       = 1'b0;
    w_stall     = 1'b0;
    w_inc       = 1'b0;
    w_clr       = 1'b0;
    w_state_nxt = r_state;
    if (rstn) begin
      case (r_state)
        OWN_CPU: begin
          if (!bus.host_req) begin
            w_cpu_own = 1'b1;
            w_clr     = 1'b1;
          end else if (!bus.cpu_req) begin
            w_host_own = 1'b1;
            w_gnt      = 1'b1;
            w_clr      = 1'b1;
          end else if (w_hit) begin
            w_host_own = 1'b1;
            w_gnt      = 1'b1;
            w_stall    = 1'b1;
            w_clr      = 1'b1;
          end else begin
            w_cpu_own = 1'b1;
            w_inc     = 1'b1;
          end
          if (w_gnt && bus.host_lock) w_state_nxt = OWN_HOST;
        end
        OWN_HOST: begin
          w_host_own = bus.host_req;
          w_gnt      = bus.host_req;
          w_stall    = bus.cpu_req;
          w_clr      = 1'b1;
          if (!bus.host_req || !bus.host_lock) w_state_nxt = OWN_CPU;
        end
        default: w_state_nxt = OWN_CPU;
      endcase
    end
  end

  // A stalled CPU never reaches the memory; with no requester the CPU signals are parked on the bus.
  assign w_own_req  = w_host_own ? bus.host_req : (w_cpu_own & bus.cpu_req);
  assign w_own_we   = w_host_own ? bus.host_we  : bus.cpu_we;
  assign w_mem_addr = w_host_own ? bus.host_addr  : bus.cpu_addr;
  assign w_mem_din  = w_host_own ? bus.host_wdata : bus.cpu_wdata;

  assign bus.mem_we      = w_own_we & w_own_req;
  assign bus.mem_oe      = w_own_req & ~w_own_we;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_din     = w_mem_din;
  assign bus.cpu_rdata   = w_cpu_own ? bus.mem_dout : '0;
  assign bus.cpu_stall   = w_stall;
  assign bus.host_gnt    = w_gnt;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= OWN_CPU;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_host_rvalid <= w_gnt & ~bus.host_we;
      if (w_gnt && !bus.host_we) r_host_rdata <= bus.mem_dout;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_host_cnt;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_host_cnt  <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'(1);
      if (w_gnt)   r_host_cnt  <= r_host_cnt + 32'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign host_cnt  = r_host_cnt;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store path and an external host port used for debug and preload.
- Sits between the CPU datapath (ALU result as address, rb_data as write data) and the data_mem instance.
- Stalls the CPU through a PC-hold signal whenever the host owns the memory.
- Bounds host waiting with a starvation counter; supports a locked host burst.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width.
- MAX_WAIT, 4, host wait cycles (1..2^WAIT_W-1) after which the host pre-empts the CPU.
- WAIT_W, 3, wait counter width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU memory access this cycle (mem_r | mem_w).
- cpu_we  in  1  CPU write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  CPU load data, combinational from memory.
- cpu_stall  out  1  hold PC and suppress reg_w this cycle.
- host_req  in  1  host access request, held until granted.
- host_lock  in  1  keep ownership after the current host access.
- host_we  in  1  host write.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rvalid  out  1  registered read data valid.
- host_rdata  out  DATA_W  registered host read data.
- mem_we  out  1  to data_mem we.
- mem_oe  out  1  to data_mem oe.
- mem_addr  out  ADDR_W  to data_mem d_addr.
- mem_din  out  DATA_W  to data_mem d_in.
- mem_dout  in  DATA_W  from data_mem d_out (async read).

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low on rstn.
- Memory timing: read is combinational, write commits on the clk rising edge. One access per cycle; the owner is chosen combinationally from the requests and the registered state.
- State machine (state, wait_cnt): states OWN_CPU and OWN_HOST. Reset values: state=OWN_CPU, wait_cnt=0, host_rvalid=0, host_rdata=0.
- OWN_CPU, host_req=0:
  - CPU drives the memory; cpu_stall=0; host_gnt=0.
- OWN_CPU, host_req=1 and cpu_req=0:
  - Host is granted immediately; host_gnt=1; cpu_stall=0; wait_cnt cleared.
- OWN_CPU, host_req=1 and cpu_req=1:
  - CPU is served and wait_cnt increments.
  - When wait_cnt==MAX_WAIT, the host is granted in that cycle, cpu_stall=1, and wait_cnt clears.
- Lock entry: a host grant with host_lock=1 moves to OWN_HOST next cycle.
- OWN_HOST:
  - cpu_stall=cpu_req. A stalled CPU re-presents the same access next cycle.
  - host_gnt=host_req.
  - host_lock=0 at a grant, or host_req=0, returns to OWN_CPU next cycle.
- Mux rules:
  - mem_we = owner_we & owner_req.
  - mem_oe = owner_req & ~owner_we.
  - mem_addr and mem_din come from the owner. With no requester they carry the CPU signals; mem_we=0, mem_oe=0.
- cpu_rdata = mem_dout whenever the CPU is the owner, otherwise 0.
- host_rvalid is 1 in the cycle after a granted host read; host_rdata captures mem_dout in that grant cycle. Host writes never assert host_rvalid.
- Simultaneous write collision is impossible: exactly one owner per cycle.
- Wait counter saturates at MAX_WAIT and never wraps.
- Reset mid-burst: returns to OWN_CPU. Any pending host_rvalid is dropped.
- cpu_stall must never be 1 when cpu_req=0.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds output ports stall_cnt[31:0] (cycles with cpu_stall=1) and host_cnt[31:0] (host grants). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package: state encoding (OWN_CPU=1'b0, OWN_HOST=1'b1) and default widths DATA_W and ADDR_W, shared with the CPU top.
- One sub-module, arb_wait_counter: the saturating starvation counter with inc, clr and hit outputs.
- The state machine and muxing stay in dmem_arbiter.

Test Plan:
1. CPU-only traffic: store 0xDEADBEEF to address 0x10, then load from 0x10 -> cpu_rdata=0xDEADBEEF; cpu_stall never 1; host_gnt=0.
2. Host read while CPU idle: host_req=1, addr=0x10 -> host_gnt=1 the same cycle; next cycle host_rvalid=1, host_rdata=0xDEADBEEF.
3. Contention, MAX_WAIT=4: cpu_req and host_req held high -> CPU served 4 cycles, host granted in cycle 5 with cpu_stall=1, CPU resumes in cycle 6.
4. Locked burst: host writes 0x1,0x2,0x3 to 0x20,0x24,0x28 with host_lock=1 until the last beat -> cpu_stall=1 for all 3 cycles; CPU loads afterwards return the written values.
5. Reset pulse in the middle of a locked burst -> state=OWN_CPU, host_rvalid=0, cpu_stall=0 immediately, with no write committed on the reset cycle.
6. With DMEM_ARB_STATS_EN defined, scenario 4 -> stall_cnt=3, host_cnt=3.
